// File: rtl/alu_mc_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states and the flag bundle.
package alu_mc_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_DIV = 4'd3,
    OP_AND = 4'd4,
    OP_OR  = 4'd5,
    OP_XOR = 4'd6,
    OP_NOT = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9,
    OP_ROL = 4'd10,
    OP_ROR = 4'd11
  } alu_op_e;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = S_IDLE,
    ST_MUL  = S_MUL,
    ST_DIV  = S_DIV,
    ST_DONE = S_DONE
  } alu_state_e;

  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } alu_flags_t;

endpackage

// File: rtl/alu_mc_iter.sv
// Shared iterative engine: unsigned shift-add multiply and restoring divide,
// one bit per cycle. {res_hi,res_lo} = product, or remainder/quotient for divide.
module alu_mc_iter #(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d, busy_q, busy_d, done_q, done_d;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;

  // lo holds the multiplier (MUL) or the dividend being shifted into quotient bits (DIV)
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};

  always_comb begin
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    if (start) begin
      hi_d     = '0;
      lo_d     = is_div ? a : b;
      opnd_d   = is_div ? b : a;
      is_div_d = is_div;
      cnt_d    = CNT_W'(WIDTH);
      busy_d   = 1'b1;
    end else if (busy_q) begin
      if (is_div_q) begin
        // top bit of the difference is the borrow: partial remainder < divisor
        if (!div_diff[WIDTH]) begin
          hi_d = div_diff[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b1};
        end else begin
          hi_d = div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], 1'b0};
        end
      end else begin
        {hi_d, lo_d} = {mul_sum, lo_q[WIDTH-1:1]};
      end
      cnt_d = cnt_q - CNT_W'(1);
      if (cnt_q == CNT_W'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign res_lo = lo_q;
  assign res_hi = hi_q;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready in and out. Define ALU_MC_ITER_EN for the
// iterative MUL/DIV engine; otherwise MUL/DIV are single-cycle combinational.
module alu_mc
  import alu_mc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  alu_op_e          op,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_z,
  output logic             flag_n,
  output logic             flag_c,
  output logic             flag_v,
  output logic             div_zero
);

  localparam int SHAMT_W = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic [WIDTH-1:0] result_q, result_d, result_hi_q, result_hi_d;
  alu_flags_t       flags_q, flags_d;
  logic             div_zero_q, div_zero_d;
  logic             accept, core_busy;

  logic [WIDTH-1:0] f_res, f_hi;
  logic             f_c, f_v, f_dz, f_legal, f_iter;

  logic [SHAMT_W-1:0] shamt, rot_amt;
  logic [SHAMT_W:0]   rot_ext, rot_inv;
  logic [WIDTH:0]     add_w, sub_w, shl_w, shr_w;
  logic [WIDTH-1:0]   rol_w, ror_w;

  assign shamt = op_b[SHAMT_W-1:0];
  // Rotation is modulo WIDTH; only matters when WIDTH is not a power of two
  assign rot_amt = ({1'b0, shamt} >= (SHAMT_W+1)'(WIDTH)) ? shamt - SHAMT_W'(WIDTH) : shamt;
  assign rot_ext = {1'b0, rot_amt};
  assign rot_inv = (SHAMT_W+1)'(WIDTH) - rot_ext;

  assign add_w = {1'b0, op_a} + {1'b0, op_b};
  assign sub_w = {1'b0, op_a} - {1'b0, op_b};
  assign shl_w = {1'b0, op_a} << shamt;
  assign shr_w = {op_a, 1'b0} >> shamt;
  assign rol_w = (op_a << rot_ext) | (op_a >> rot_inv);
  assign ror_w = (op_a >> rot_ext) | (op_a << rot_inv);

`ifdef ALU_MC_ITER_EN
  logic             eng_start, eng_busy, eng_done;
  logic [WIDTH-1:0] eng_lo, eng_hi;

  assign eng_start = accept && f_iter;
  assign core_busy = eng_busy;

  alu_mc_iter #(.WIDTH(WIDTH)) u_iter (
    .clock  (clock),
    .reset  (reset),
    .start  (eng_start),
    .is_div (op == OP_DIV),
    .a      (op_a),
    .b      (op_b),
    .busy   (eng_busy),
    .done   (eng_done),
    .res_lo (eng_lo),
    .res_hi (eng_hi)
  );
`else
  logic [2*WIDTH-1:0] prod_w;
  logic [WIDTH-1:0]   quo_w, rem_w;

  assign core_busy = 1'b0;
  assign prod_w    = {{WIDTH{1'b0}}, op_a} * {{WIDTH{1'b0}}, op_b};
  assign quo_w     = (op_b == '0) ? '1 : op_a / op_b;
  assign rem_w     = (op_b == '0) ? op_a : op_a % op_b;
`endif

  always_comb begin
    f_res   = '0;
    f_hi    = '0;
    f_c     = 1'b0;
    f_v     = 1'b0;
    f_dz    = 1'b0;
    f_legal = 1'b1;
    f_iter  = 1'b0;
    case (op)
      OP_ADD: begin
        f_res = add_w[WIDTH-1:0];
        f_c   = add_w[WIDTH];
        f_v   = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (add_w[WIDTH-1] != op_a[WIDTH-1]);
      end
      OP_SUB: begin
        f_res = sub_w[WIDTH-1:0];
        f_c   = sub_w[WIDTH];
        f_v   = (op_a[WIDTH-1] != op_b[WIDTH-1]) && (sub_w[WIDTH-1] != op_a[WIDTH-1]);
      end
`ifdef ALU_MC_ITER_EN
      OP_MUL: f_iter = 1'b1;
`else
      OP_MUL: {f_hi, f_res} = prod_w;
`endif
      OP_DIV: begin
        if (op_b == '0) begin
          f_res = '1;
          f_hi  = op_a;
          f_dz  = 1'b1;
        end else begin
`ifdef ALU_MC_ITER_EN
          f_iter = 1'b1;
`else
          f_res = quo_w;
          f_hi  = rem_w;
`endif
        end
      end
      OP_AND: f_res = op_a & op_b;
      OP_OR:  f_res = op_a | op_b;
      OP_XOR: f_res = op_a ^ op_b;
      OP_NOT: f_res = ~op_a;
      // Carry is the last bit to leave; a zero amount naturally yields 0
      OP_SHL: begin
        f_res = shl_w[WIDTH-1:0];
        f_c   = shl_w[WIDTH];
      end
      OP_SHR: begin
        f_res = shr_w[WIDTH:1];
        f_c   = shr_w[0];
      end
      OP_ROL: begin
        f_res = rol_w;
        f_c   = (shamt != '0) && rol_w[0];
      end
      OP_ROR: begin
        f_res = ror_w;
        f_c   = (shamt != '0) && ror_w[WIDTH-1];
      end
      default: f_legal = 1'b0;
    endcase
  end

  assign in_ready = !reset && !core_busy &&
                    ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    flags_d     = flags_q;
    div_zero_d  = div_zero_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          if (f_iter) begin
            state_d = (op == OP_DIV) ? ST_DIV : ST_MUL;
          end else begin
            state_d     = ST_DONE;
            result_d    = f_res;
            result_hi_d = f_hi;
            flags_d.z   = f_legal && (f_res == '0);
            flags_d.n   = f_res[WIDTH-1];
            flags_d.c   = f_c;
            flags_d.v   = f_v;
            div_zero_d  = f_dz;
          end
        end else if ((state_q == ST_DONE) && out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
`ifdef ALU_MC_ITER_EN
        if (eng_done) begin
          state_d     = ST_DONE;
          result_d    = eng_lo;
          result_hi_d = eng_hi;
          flags_d.z   = (eng_lo == '0);
          flags_d.n   = eng_lo[WIDTH-1];
          flags_d.c   = 1'b0;
          flags_d.v   = 1'b0;
          div_zero_d  = 1'b0;
        end
`else
        state_d = ST_IDLE;
`endif
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      result_q    <= '0;
      result_hi_q <= '0;
      flags_q     <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      flags_q     <= flags_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign flag_z    = flags_q.z;
  assign flag_n    = flags_q.n;
  assign flag_c    = flags_q.c;
  assign flag_v    = flags_q.v;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc (WIDTH=8): behavioural model + scoreboard queue
// checked every output cycle, plus literal expectations for directed vectors.
module tb_alu_mc;
  import alu_mc_pkg::*;

`ifdef ALU_MC_ITER_EN
  localparam int ITER_LAT = 9;
`else
  localparam int ITER_LAT = 1;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  alu_op_e    op = OP_ADD;
  logic [7:0] op_a = '0;
  logic [7:0] op_b = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] result, result_hi;
  logic       flag_z, flag_n, flag_c, flag_v, div_zero;

  alu_mc #(.WIDTH(8)) dut (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .op        (op),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .result_hi (result_hi),
    .flag_z    (flag_z),
    .flag_n    (flag_n),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .div_zero  (div_zero)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [7:0] r;
    logic [7:0] rh;
    logic       z, n, c, v, dz;
    int         due;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;
  bit   seen = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Reference behaviour from the arithmetic definition of each opcode
  function automatic exp_t model(input alu_op_e o, input logic [7:0] a, input logic [7:0] b);
    exp_t e;
    int ia, ib, sa, sb, t, s;
    logic [7:0] x;
    e.r = '0; e.rh = '0; e.z = 0; e.n = 0; e.c = 0; e.v = 0; e.dz = 0; e.due = 0;
    ia = int'(a); ib = int'(b);
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    x = a;
    s = ib % 8;
    case (o)
      OP_ADD: begin t = ia + ib; e.r = 8'(t); e.c = (t > 255); t = sa + sb; e.v = (t > 127) || (t < -128); end
      OP_SUB: begin t = ia - ib; e.r = 8'(t); e.c = (ia < ib); t = sa - sb; e.v = (t > 127) || (t < -128); end
      OP_MUL: begin t = ia * ib; e.r = 8'(t); e.rh = 8'(t / 256); end
      OP_DIV: begin
        if (ib == 0) begin e.r = 8'hFF; e.rh = a; e.dz = 1; end
        else begin e.r = 8'(ia / ib); e.rh = 8'(ia % ib); end
      end
      OP_AND: e.r = a & b;
      OP_OR:  e.r = a | b;
      OP_XOR: e.r = a ^ b;
      OP_NOT: e.r = ~a;
      OP_SHL: begin for (int k = 0; k < s; k++) begin e.c = x[7]; x = {x[6:0], 1'b0}; end e.r = x; end
      OP_SHR: begin for (int k = 0; k < s; k++) begin e.c = x[0]; x = {1'b0, x[7:1]}; end e.r = x; end
      OP_ROL: begin for (int k = 0; k < s; k++) begin e.c = x[7]; x = {x[6:0], x[7]}; end e.r = x; end
      OP_ROR: begin for (int k = 0; k < s; k++) begin e.c = x[0]; x = {x[0], x[7:1]}; end e.r = x; end
      default: return e;
    endcase
    e.z = (e.r == 8'h00);
    e.n = e.r[7];
    return e;
  endfunction

  // Scoreboard: every cycle with out_valid is compared against the oldest pending op
  initial begin : compare
    forever begin
      @(negedge clock);
      if (reset) continue;
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("spurious_out_valid", {31'd0, out_valid}, 32'd0);
        end else begin
          if (!seen) begin
            chk("latency", cyc, q[0].due);
            seen = 1'b1;
          end
          chk("result", {24'd0, result}, {24'd0, q[0].r});
          chk("result_hi", {24'd0, result_hi}, {24'd0, q[0].rh});
          chk("flags_zncv", {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, q[0].z, q[0].n, q[0].c, q[0].v});
          chk("div_zero", {31'd0, div_zero}, {31'd0, q[0].dz});
          if (out_ready) begin
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end else if (q.size() > 0) begin
        chk("busy_in_ready", {31'd0, in_ready}, 32'd0);
        if (cyc > q[0].due) begin
          chk("result_timeout", cyc, q[0].due);
          void'(q.pop_front());
          seen = 1'b0;
        end
      end
    end
  end

  // Called #1 after a rising edge; returns #1 after the accepting edge
  task automatic issue(input alu_op_e o, input logic [7:0] a, input logic [7:0] b, output int waits);
    exp_t e;
    waits = 0;
    op = o; op_a = a; op_b = b; in_valid = 1'b1;
    @(negedge clock);
    while (!in_ready && waits < 100) begin
      @(negedge clock);
      waits++;
    end
    if (!in_ready) begin
      chk("accept_timeout", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clock);
    e = model(o, a, b);
    e.due = cyc + (((o == OP_MUL) || ((o == OP_DIV) && (b != 8'h00))) ? ITER_LAT : 1);
    q.push_back(e);
    $display("accept op=%0d a=%02h b=%02h -> exp r=%02h hi=%02h due=%0d", o, a, b, e.r, e.rh, e.due);
    #1;
    in_valid = 1'b0;
    op_a = 8'($urandom);
    op_b = 8'($urandom);
  endtask

  task automatic expect_lit(input string nm, input logic [7:0] r, input logic [7:0] rh,
                            input logic [3:0] zncv, input logic dz);
    int n;
    n = 0;
    @(negedge clock);
    while (!out_valid && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({nm, "_res"}, {24'd0, result}, {24'd0, r});
    chk({nm, "_hi"}, {24'd0, result_hi}, {24'd0, rh});
    chk({nm, "_zncv"}, {28'd0, flag_z, flag_n, flag_c, flag_v}, {28'd0, zncv});
    chk({nm, "_dz"}, {31'd0, div_zero}, {31'd0, dz});
    @(posedge clock);
    #1;
  endtask

  logic [19:0] burst [16];
  int w;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    burst = '{20'h0_12_34, 20'h1_34_12, 20'h2_0F_11, 20'h3_FF_10, 20'h4_F0_3C, 20'h5_F0_0F,
              20'h6_AA_FF, 20'h7_00_55, 20'h8_01_09, 20'h9_81_03, 20'hA_C3_04, 20'hB_3C_05,
              20'h3_07_00, 20'h2_00_99, 20'hC_11_22, 20'h0_80_80};

    // Reset state
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_outputs", {11'd0, result, result_hi, flag_z, flag_n, flag_c, flag_v, div_zero}, 32'd0);
    @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
    #1;

    // Directed vectors with literal expectations (flags as {z,n,c,v})
    issue(OP_ADD, 8'h7F, 8'h01, w); expect_lit("add_ovf", 8'h80, 8'h00, 4'b0101, 1'b0);
    issue(OP_ADD, 8'hFF, 8'h01, w); expect_lit("add_carry", 8'h00, 8'h00, 4'b1010, 1'b0);
    issue(OP_MUL, 8'hFF, 8'hFF, w); expect_lit("mul_ff", 8'h01, 8'hFE, 4'b0000, 1'b0);
    issue(OP_DIV, 8'd200, 8'd7, w); expect_lit("div_200_7", 8'h1C, 8'h04, 4'b0000, 1'b0);
    issue(OP_DIV, 8'h55, 8'h00, w); expect_lit("div_zero", 8'hFF, 8'h55, 4'b0100, 1'b1);
    issue(OP_ROL, 8'h81, 8'h01, w); expect_lit("rol_81", 8'h03, 8'h00, 4'b0010, 1'b0);
    issue(OP_SHR, 8'h80, 8'h07, w); expect_lit("shr_80_7", 8'h01, 8'h00, 4'b0000, 1'b0);
    issue(OP_SHL, 8'h5A, 8'h00, w); expect_lit("shl_by0", 8'h5A, 8'h00, 4'b0000, 1'b0);
    issue(alu_op_e'(4'hF), 8'h12, 8'h34, w); expect_lit("illegal", 8'h00, 8'h00, 4'b0000, 1'b0);
    issue(OP_SUB, 8'h10, 8'h20, w); expect_lit("sub_borrow", 8'hF0, 8'h00, 4'b0110, 1'b0);
    issue(OP_SUB, 8'h80, 8'h01, w); expect_lit("sub_ovf", 8'h7F, 8'h00, 4'b0001, 1'b0);
    issue(OP_ROR, 8'h01, 8'h01, w); expect_lit("ror_01", 8'h80, 8'h00, 4'b0110, 1'b0);

    // Backpressure: hold the XOR result, then release together with a new AND
    out_ready = 1'b0;
    issue(OP_XOR, 8'hF0, 8'h3C, w); expect_lit("xor_hold", 8'hCC, 8'h00, 4'b0100, 1'b0);
    repeat (4) @(posedge clock);
    #1;
    chk("xor_still_valid", {31'd0, out_valid}, 32'd1);
    out_ready = 1'b1;
    issue(OP_AND, 8'hA5, 8'h0F, w);
    chk("b2b_same_cycle_accept", w, 0);
    expect_lit("and_b2b", 8'h05, 8'h00, 4'b0000, 1'b0);

    // Back-to-back burst with random consumer stalls
    fork
      begin
        repeat (60) begin
          @(posedge clock);
          #1 out_ready = 1'($urandom_range(0, 1));
        end
        out_ready = 1'b1;
      end
    join_none
    for (int i = 0; i < 16; i++)
      issue(alu_op_e'(burst[i][19:16]), burst[i][15:8], burst[i][7:0], w);
    repeat (70) @(posedge clock);
    #1;
    chk("burst_drained", q.size(), 0);

    // Asynchronous reset in the middle of a MUL
    issue(OP_ADD, 8'h7F, 8'h01, w); expect_lit("pre_rst_add", 8'h80, 8'h00, 4'b0101, 1'b0);
    issue(OP_MUL, 8'h12, 8'h34, w);
    repeat (3) @(posedge clock);
    #2;
    q.delete();
    seen = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("midrst_outputs", {11'd0, result, result_hi, flag_z, flag_n, flag_c, flag_v, div_zero}, 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    chk("after_rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("after_rst_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clock);
    #1;
    issue(OP_ADD, 8'h22, 8'h33, w); expect_lit("post_rst_add", 8'h55, 8'h00, 4'b0000, 1'b0);

    repeat (5) @(posedge clock);
    #1;
    chk("final_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
